spi_crc_master_mc: RTL and testbench
====================================

Name: spi_crc_master_mc

Overview:
- Parametrised, multi-slave, full-duplex SPI master with CRC generation on MOSI and CRC checking on MISO.
- Each transaction shifts a DATA_W-bit word followed by its CRC_W-bit CRC out on MOSI.
- In the same frame it receives a DATA_W-bit word plus CRC from the selected slave and flags any CRC mismatch.
- It succeeds the fixed 8-bit single-slave master/slave pair and sits between the system-side request logic and up to NUM_CS SPI slaves.

Parameters:
DATA_W, 8, payload bits per frame
CRC_W, 8, CRC bits per frame (>=2)
CRC_POLY, 8'h07, CRC generator polynomial, implicit top bit, width CRC_W
CRC_INIT, 0, CRC register seed at frame start, width CRC_W
CLK_DIV, 4, clk cycles per sclk half-period (>=1)
NUM_CS, 3, number of chip selects (1..2**SEL_W)
SEL_W, 2, width of sel

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
newd  in  1  start request, sampled in IDLE only
din  in  DATA_W  transmit payload, latched on accepted newd
sel  in  SEL_W  target slave index, latched on accepted newd
miso  in  1  serial data from slaves
sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
cs_n  out  NUM_CS  active-low chip selects, at most one low
mosi  out  1  serial data to slaves
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at frame end
rx_data  out  DATA_W  received payload, updated with done
rx_crc_err  out  1  received CRC mismatch, updated with done, held until next done
sel_err  out  1  one-cycle pulse when newd is rejected for sel >= NUM_CS

Behaviour:
- Reset is asynchronous and active-low. While rst=0 (no clock needed), all outputs are driven to:
  - sclk=0, mosi=0, cs_n all 1, busy=0, done=0, sel_err=0, rx_data=0, rx_crc_err=0.
  - Internal state returns to IDLE.
- Reset mid-frame aborts the frame immediately. No done is produced.
- FSM states: IDLE, SETUP, SHIFT, HOLD, DONE.
- IDLE:
  - newd=1 with sel<NUM_CS latches din and sel, loads the tx CRC and rx CRC registers with CRC_INIT, and moves to SETUP.
  - newd=1 with sel>=NUM_CS pulses sel_err for 1 cycle and stays in IDLE.
- SETUP (CLK_DIV cycles):
  - cs_n[sel]=0.
  - mosi = din MSB.
  - sclk=0.
- SHIFT (DATA_W+CRC_W sclk periods, each 2*CLK_DIV cycles):
  - Rising sclk edge: sample miso into the rx shifter and the rx CRC.
  - Falling sclk edge: present the next bit on mosi.
  - TX bit order: din MSB-first, then the tx CRC MSB-first. The tx CRC is frozen after the last payload bit.
  - The first DATA_W received bits form rx_data. The next CRC_W received bits are compared to the rx CRC computed over rx_data.
- CRC update per bit b (serial, MSB-first, no reflection, no final XOR):
  - fb = crc[CRC_W-1] ^ b
  - crc = (crc << 1) ^ (fb ? CRC_POLY : 0)
  - With DATA_W=8 and defaults: CRC(0xA5)=0x72, CRC(0xFF)=0xF3, CRC(0x00)=0x00.
- HOLD (CLK_DIV cycles): sclk=0, cs_n held low.
- DONE (1 cycle):
  - cs_n all 1.
  - done=1; rx_data and rx_crc_err are registered.
  - busy is still 1.
  - Next cycle returns to IDLE.
- Latency: done is high exactly 2*CLK_DIV*(DATA_W+CRC_W+1)+1 cycles after the newd acceptance cycle. With defaults that is 137.
- newd while busy is ignored. It is not queued.
- newd on the cycle after DONE is accepted, giving back-to-back frames with a minimum of 1 idle cycle.
- mosi returns to 0 in IDLE.

Optional Feature:
- Macro SPI_CRC_INJECT_EN.
- When defined:
  - Adds input port crc_inject (1 bit), latched together with din.
  - When latched high, bit 0 of the transmitted CRC is inverted, for slave-side error testing.
  - rx checking is unaffected.
- When undefined:
  - The port is absent.
  - The transmitted CRC is always correct.

Test Plan:
- Reset: assert rst=0 mid-SHIFT -> cs_n=3'b111, sclk=0, mosi=0, busy=0 on the same cycle; no done pulse.
- newd with din=0xA5, sel=0; slave model returns 0xFF then CRC 0xF3:
  - MOSI bit stream is A5 then 72, MSB-first, one bit per 8 clk.
  - cs_n=3'b110 throughout the frame.
  - done at cycle 137; rx_data=0xFF, rx_crc_err=0.
- Same frame with the slave returning CRC 0xF2 -> rx_data=0xFF, rx_crc_err=1 held until the next done. The next clean frame clears it to 0.
- Chip select and sel range:
  - sel=2 -> cs_n=3'b011.
  - sel=3 -> sel_err pulses 1 cycle, busy stays 0, cs_n stays 3'b111.
- newd pulsed repeatedly during a frame -> exactly one done. A second newd on the cycle after done starts a new frame with CLK_DIV=1; done arrives 35 cycles after acceptance.
- With SPI_CRC_INJECT_EN, din=0x00, crc_inject=1 -> transmitted CRC byte = 0x01.

Source files
------------

// File: rtl/spi_crc_master_mc.sv
// rtl/spi_crc_master_mc.sv - multi-slave full-duplex SPI master with CRC on MOSI and CRC check on MISO
//
// Purpose:
//   Shifts a DATA_W-bit payload followed by its CRC_W-bit CRC out on mosi
//   (SPI mode 0, MSB-first) to one of NUM_CS slaves.  In the same frame it
//   receives DATA_W payload bits plus CRC_W CRC bits on miso and flags any
//   mismatch against the CRC it computes over the received payload.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   newd        start request, only honoured in IDLE
//   din         transmit payload, latched on an accepted newd
//   sel         target slave index, latched on an accepted newd
//   miso        serial data from the slaves
//   crc_inject  (SPI_CRC_INJECT_EN only) invert bit 0 of the transmitted CRC
//   sclk        SPI clock, idle low
//   cs_n        active-low chip selects, at most one low
//   mosi        serial data to the slaves
//   busy        high whenever the FSM is not IDLE
//   done        one-cycle pulse in the final frame cycle
//   rx_data     received payload, valid with done
//   rx_crc_err  received CRC mismatch, valid with done, held until next done
//   sel_err     one-cycle pulse when newd is rejected for sel >= NUM_CS
//
// Optional feature macro: SPI_CRC_INJECT_EN

module spi_crc_master_mc #(
  parameter int               DATA_W   = 8,
  parameter int               CRC_W    = 8,
  parameter logic [CRC_W-1:0] CRC_POLY = 'h07,
  parameter logic [CRC_W-1:0] CRC_INIT = '0,
  parameter int               CLK_DIV  = 4,
  parameter int               NUM_CS   = 3,
  parameter int               SEL_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              newd,
  input  logic [DATA_W-1:0] din,
  input  logic [SEL_W-1:0]  sel,
  input  logic              miso,
`ifdef SPI_CRC_INJECT_EN
  input  logic              crc_inject,
`endif
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_crc_err,
  output logic              sel_err
);

  localparam int NBITS = DATA_W + CRC_W;
  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(NBITS + 1);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] DATA_BITS = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] LAST_PAY  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] ALL_BITS  = BIT_W'(NBITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  div_cnt;
  logic              sclk_hi;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [CRC_W-1:0]  tx_crc;
  logic [CRC_W-1:0]  rx_crc;
  logic [CRC_W-1:0]  rx_crc_in;
  logic [SEL_W-1:0]  sel_q;
  logic              inject_q;

  logic div_end;
  logic sel_ok;
  logic accept;
  logic rise_evt;
  logic fall_evt;
  logic frame_act;

  // Serial CRC step: MSB-first, no reflection, no final XOR.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb = c[CRC_W-1] ^ b;
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

  assign div_end = (div_cnt == DIV_LAST);
  assign sel_ok  = (int'(sel) < NUM_CS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Each SHIFT bit is a high half (entered on the rising-edge event) then a
  // low half; the low half of the last bit runs out in SHIFT before HOLD so
  // every bit gets a full sclk period.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rise_evt  = 1'b0;
    fall_evt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (newd && sel_ok) begin
          accept    = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (div_end) begin
          rise_evt  = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (div_end) begin
          if (sclk_hi)                    fall_evt  = 1'b1;
          else if (bit_cnt == ALL_BITS)   state_nxt = S_HOLD;
          else                            rise_evt  = 1'b1;
        end
      end
      S_HOLD: begin
        if (div_end) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign frame_act = (state == S_SETUP) || (state == S_SHIFT) || (state == S_HOLD);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign sclk      = (state == S_SHIFT) && sclk_hi;
  assign cs_n      = frame_act ? ~(NUM_CS'(1) << sel_q) : '1;
  // Payload bits come from tx_sh, then the (already final) CRC shifts out.
  assign mosi      = frame_act && ((bit_cnt < DATA_BITS) ? tx_sh[DATA_W-1] : tx_crc[CRC_W-1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt    <= '0;
      sclk_hi    <= 1'b0;
      bit_cnt    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      tx_crc     <= '0;
      rx_crc     <= '0;
      rx_crc_in  <= '0;
      sel_q      <= '0;
      inject_q   <= 1'b0;
      rx_data    <= '0;
      rx_crc_err <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      sel_err <= (state == S_IDLE) && newd && !sel_ok;

      if (state == S_IDLE || state == S_DONE || div_end) div_cnt <= '0;
      else                                                div_cnt <= div_cnt + 1'b1;

      if (accept) begin
        tx_sh    <= din;
        sel_q    <= sel;
        tx_crc   <= CRC_INIT;
        rx_crc   <= CRC_INIT;
        bit_cnt  <= '0;
        sclk_hi  <= 1'b0;
`ifdef SPI_CRC_INJECT_EN
        inject_q <= crc_inject;
`else
        inject_q <= 1'b0;
`endif
      end

      if (rise_evt) begin
        sclk_hi <= 1'b1;
        if (bit_cnt < DATA_BITS) begin
          rx_sh  <= {rx_sh[DATA_W-2:0], miso};
          rx_crc <= crc_step(rx_crc, miso);
        end else begin
          rx_crc_in <= {rx_crc_in[CRC_W-2:0], miso};
        end
      end

      if (fall_evt) begin
        sclk_hi <= 1'b0;
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt < DATA_BITS) begin
          tx_sh  <= {tx_sh[DATA_W-2:0], 1'b0};
          // The optional corruption is folded in as the CRC is finalised.
          tx_crc <= crc_step(tx_crc, tx_sh[DATA_W-1])
                    ^ {{(CRC_W-1){1'b0}}, inject_q && (bit_cnt == LAST_PAY)};
        end else begin
          tx_crc <= {tx_crc[CRC_W-2:0], 1'b0};
        end
      end

      if (state == S_HOLD && div_end) begin
        rx_data    <= rx_sh;
        rx_crc_err <= (rx_crc_in != rx_crc);
      end
    end
  end

endmodule

// File: tb/tb_spi_crc_master_mc.sv
// tb/tb_spi_crc_master_mc.sv - self-checking bench for spi_crc_master_mc

module tb_spi_crc_master_mc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default-parameter instance
  logic       newd, miso, sclk, mosi, busy, done, rx_crc_err, sel_err, crc_inject;
  logic [7:0] din, rx_data;
  logic [1:0] sel;
  logic [2:0] cs_n;

  // CLK_DIV=1 instance
  logic       newd1, miso1, sclk1, mosi1, busy1, done1, rx_crc_err1, sel_err1;
  logic [7:0] din1, rx_data1;
  logic [1:0] sel1;
  logic [2:0] cs_n1;

  spi_crc_master_mc dut (
    .clk(clk), .rst(rst), .newd(newd), .din(din), .sel(sel), .miso(miso),
`ifdef SPI_CRC_INJECT_EN
    .crc_inject(crc_inject),
`endif
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .busy(busy), .done(done),
    .rx_data(rx_data), .rx_crc_err(rx_crc_err), .sel_err(sel_err)
  );

  spi_crc_master_mc #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .newd(newd1), .din(din1), .sel(sel1), .miso(miso1),
`ifdef SPI_CRC_INJECT_EN
    .crc_inject(1'b0),
`endif
    .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .busy(busy1), .done(done1),
    .rx_data(rx_data1), .rx_crc_err(rx_crc_err1), .sel_err(sel_err1)
  );

  // slave model: bit 15 first, next bit after each falling sclk
  logic [15:0] slave_word;
  logic [4:0]  slave_idx;
  assign miso = slave_word[4'd15 - slave_idx[3:0]];

  typedef struct {
    logic [7:0]  din;
    logic [1:0]  sel;
    logic [15:0] slave;
    logic [7:0]  rx;
    logic        err;
    logic [15:0] mosi;
    logic [2:0]  cs;
  } vec_t;

  typedef struct {
    logic [7:0]  rx;
    logic        err;
    logic [15:0] mosi;
    logic [2:0]  cs;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  int          checks = 0, errors = 0;
  int          cyc = 0, accept_cyc = 0, done_cnt = 0, exp_dones = 0;
  logic [15:0] mosi_cap;
  logic        cs_bad, sclk_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic monitor_step();
    exp_t e;
    cyc++;
    if (rst && newd && !busy && sel < 2'd3) begin
      accept_cyc = cyc;
      mosi_cap   = '0;
      cs_bad     = 1'b0;
    end
    if (busy && !done && sb.size() > 0 && cs_n !== sb[0].cs) cs_bad = 1'b1;
    if (sclk && !sclk_prev) mosi_cap = {mosi_cap[14:0], mosi};
    if (&cs_n) slave_idx = '0;
    else if (!sclk && sclk_prev) slave_idx = slave_idx + 5'd1;
    sclk_prev = sclk;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("latency", 32'(cyc - accept_cyc), 32'd137);
        chk("rx_data", 32'(rx_data), 32'(e.rx));
        chk("rx_crc_err", 32'(rx_crc_err), 32'(e.err));
        chk("mosi_stream", 32'(mosi_cap), 32'(e.mosi));
        chk("cs_hold", 32'(cs_bad), 32'd0);
      end
    end
  endtask

  task automatic start_frame(input logic [7:0] d, input logic [1:0] s, input logic [15:0] sw, input exp_t e);
    slave_word = sw;
    sb.push_back(e);
    @(posedge clk); #1;
    newd = 1'b1; din = d; sel = s;
    @(posedge clk); #1;
    newd = 1'b0;
  endtask

  task automatic wait_done(input int n0, input string name);
    int n;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done_cnt > n0) break;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
    @(negedge clk);
  endtask

  task automatic dut1_frame(output int lat);
    lat = -1;
    @(posedge clk); #1;
    newd1 = 1'b1; din1 = 8'h5A; sel1 = 2'd1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done1) begin lat = n; break; end
      if (n == 0) begin @(posedge clk); #1; newd1 = 1'b0; end
    end
  endtask

  initial begin
    int   n0, lat;
    exp_t e;
    newd = 0; din = 0; sel = 0; crc_inject = 0;
    newd1 = 0; din1 = 0; sel1 = 0; miso1 = 0;
    slave_word = '0; slave_idx = '0; sclk_prev = 0; mosi_cap = '0; cs_bad = 0;
    fork
      forever begin @(negedge clk); monitor_step(); end
      begin #2000000; $display("FAIL watchdog actual=timeout required=finish"); $fatal(1, "watchdog"); end
    join_none

    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_cs_n", 32'(cs_n), 32'h7);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sel_err", 32'(sel_err), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_rx_crc_err", 32'(rx_crc_err), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    vecs[0] = '{8'hA5, 2'd0, 16'hFFF3, 8'hFF, 1'b0, 16'hA572, 3'b110};
    vecs[1] = '{8'hA5, 2'd0, 16'hFFF2, 8'hFF, 1'b1, 16'hA572, 3'b110};
    vecs[2] = '{8'hFF, 2'd2, 16'h0000, 8'h00, 1'b0, 16'hFFF3, 3'b011};
    vecs[3] = '{8'h00, 2'd1, 16'hA572, 8'hA5, 1'b0, 16'h0000, 3'b101};
    vecs[4] = '{8'hFF, 2'd1, 16'h00F3, 8'h00, 1'b1, 16'hFFF3, 3'b101};
    vecs[5] = '{8'hA5, 2'd2, 16'hFFF3, 8'hFF, 1'b0, 16'hA572, 3'b011};

    for (int i = 0; i < 6; i++) begin
      if (i > 0) chk("crc_err_held", 32'(rx_crc_err), 32'(vecs[i-1].err));
      n0 = done_cnt;
      e = '{vecs[i].rx, vecs[i].err, vecs[i].mosi, vecs[i].cs};
      start_frame(vecs[i].din, vecs[i].sel, vecs[i].slave, e);
      exp_dones++;
      wait_done(n0, "vec");
      chk("idle_mosi", 32'(mosi), 0);
    end

    // out-of-range select
    @(posedge clk); #1;
    newd = 1'b1; sel = 2'd3; din = 8'h11;
    @(posedge clk); #1;
    newd = 1'b0; sel = 2'd0;
    @(negedge clk);
    chk("sel_err_pulse", 32'(sel_err), 1);
    chk("sel_err_busy", 32'(busy), 0);
    chk("sel_err_cs_n", 32'(cs_n), 32'h7);
    @(negedge clk);
    chk("sel_err_one_cycle", 32'(sel_err), 0);
    chk("sel_err_still_idle", 32'(busy), 0);

    // newd hammered during a frame is ignored
    n0 = done_cnt;
    start_frame(8'hA5, 2'd0, 16'hFFF3, '{8'hFF, 1'b0, 16'hA572, 3'b110});
    exp_dones++;
    for (int k = 0; k < 12; k++) begin
      repeat (8) @(posedge clk);
      #1 newd = 1'b1; din = 8'h3C;
      @(posedge clk); #1 newd = 1'b0;
    end
    wait_done(n0, "busy_newd");
    repeat (200) @(negedge clk);
    chk("one_done_per_frame", 32'(done_cnt - n0), 1);

    // CLK_DIV=1 instance, back-to-back frames
    dut1_frame(lat);
    chk("div1_latency", 32'(lat), 35);
    chk("div1_rx_data", 32'(rx_data1), 0);
    chk("div1_rx_crc_err", 32'(rx_crc_err1), 0);
    dut1_frame(lat);
    chk("div1_back_to_back_latency", 32'(lat), 35);

`ifdef SPI_CRC_INJECT_EN
    crc_inject = 1'b1;
    n0 = done_cnt;
    start_frame(8'h00, 2'd0, 16'h0000, '{8'h00, 1'b0, 16'h0001, 3'b110});
    exp_dones++;
    wait_done(n0, "inject");
    crc_inject = 1'b0;
`endif

    // reset in the middle of SHIFT
    n0 = done_cnt;
    start_frame(8'hA5, 2'd0, 16'hFFF3, '{8'hFF, 1'b0, 16'hA572, 3'b110});
    repeat (60) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_sclk", 32'(sclk), 0);
    chk("mid_rst_mosi", 32'(mosi), 0);
    chk("mid_rst_cs_n", 32'(cs_n), 32'h7);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rx_data", 32'(rx_data), 0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b1;
    repeat (200) @(negedge clk);
    chk("no_done_after_reset", 32'(done_cnt - n0), 0);
    chk("done_total", 32'(done_cnt), 32'(exp_dones));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
